// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 serial transmitter on ser_tx, with a per-frame latched bit period.
// Optional CRLF_EXPAND_EN: a popped 0x0D is followed by an inserted 0x0A frame.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DIV_WIDTH-1:0]         cfg_divider,
  input  logic [7:0]                   data,
  input  logic                         valid,
  output logic                         ready,
  output logic                         ser_tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q, level_d;
  logic            push, pop;
  logic [7:0]      head;

  // Transmitter state
  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] clk_cnt_q, clk_cnt_d;
  logic [DIV_WIDTH-1:0] bit_len_q, bit_len_d;
  logic [DIV_WIDTH-1:0] div_sat;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 ser_tx_q, tx_bit;
  logic                 bit_done;
  logic                 load_head;
`ifdef CRLF_EXPAND_EN
  logic                 lf_pending_q, lf_pending_d;
`endif

  assign ready      = (level_q != LvlW'(FIFO_DEPTH));
  assign push       = valid && ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign ser_tx     = ser_tx_q;
  assign busy       = (state_q != StIdle) || (level_q != '0);

  assign div_sat  = (cfg_divider < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_divider;
  assign bit_done = (clk_cnt_q == bit_len_q - DIV_WIDTH'(1));

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_len_d = bit_len_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_bit    = 1'b1;
    load_head = 1'b0;
    pop       = 1'b0;
`ifdef CRLF_EXPAND_EN
    lf_pending_d = lf_pending_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (level_q != '0) load_head = 1'b1;
      end
      StStart: begin
        tx_bit = 1'b0;
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + DIV_WIDTH'(1);
        end
      end
      StData: begin
        tx_bit = shift_q[0];
        if (bit_done) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + DIV_WIDTH'(1);
        end
      end
      StStop: begin
        if (bit_done) begin
          clk_cnt_d = '0;
`ifdef CRLF_EXPAND_EN
          if (lf_pending_q) begin
            // Inserted LF reuses the CR's FIFO entry, so no pop here.
            lf_pending_d = 1'b0;
            shift_d      = 8'h0A;
            bit_len_d    = div_sat;
            state_d      = StStart;
          end else if (level_q != '0) begin
            load_head = 1'b1;
          end else begin
            state_d = StIdle;
          end
`else
          if (level_q != '0) begin
            load_head = 1'b1;
          end else begin
            state_d = StIdle;
          end
`endif
        end else begin
          clk_cnt_d = clk_cnt_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_head) begin
      pop       = 1'b1;
      shift_d   = head;
      bit_len_d = div_sat;
      clk_cnt_d = '0;
      state_d   = StStart;
`ifdef CRLF_EXPAND_EN
      lf_pending_d = (head == 8'h0D);
`endif
    end
  end

  // Storage needs no reset; level and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      clk_cnt_q <= '0;
      bit_len_q <= DIV_WIDTH'(2);
      bit_idx_q <= '0;
      shift_q   <= '0;
      ser_tx_q  <= 1'b1;
`ifdef CRLF_EXPAND_EN
      lf_pending_q <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q   <= level_d;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_len_q <= bit_len_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      // Line is driven one cycle behind the FSM so a pop is followed by the start bit.
      ser_tx_q  <= tx_bit;
`ifdef CRLF_EXPAND_EN
      lf_pending_q <= lf_pending_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected frames queued at push time, serial monitor checks them.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cfg_divider;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        ser_tx;
  logic        busy;
  logic [4:0]  fifo_level;

  uart_tx_fifo #(
    .FIFO_DEPTH(16),
    .DIV_WIDTH (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_divider(cfg_divider),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         l;
  } exp_t;

  exp_t exp_q[$];
  int   starts[$];
  bit   in_frame = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_push_cyc = 0;
  int   exp_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: each accepted byte becomes one frame (CR also yields an LF frame).
  task automatic model_push(input logic [7:0] b, input int l);
    exp_t e;
    e.b = b;
    e.l = l;
    exp_q.push_back(e);
    exp_count++;
`ifdef CRLF_EXPAND_EN
    if (b == 8'h0D) begin
      e.b = 8'h0A;
      exp_q.push_back(e);
      exp_count++;
    end
`endif
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_byte(input logic [7:0] b, input int l);
    int guard = 0;
    valid = 1'b1;
    data  = b;
    while (ready !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      chk(1'b0 == ready, "push_accept_timeout", ready, 1);
    end else begin
      model_push(b, l);
      last_push_cyc = cyc;
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic wait_until_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_start(input int n);
    int guard = 0;
    while (starts.size() < n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk(starts.size() >= n, "frame_start_seen", starts.size(), n);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || in_frame) && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    chk(exp_q.size() == 0 && !in_frame, "drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk(busy == 1'b0, "idle_busy", busy, 0);
    chk(fifo_level == 5'd0, "idle_level", fifo_level, 0);
  endtask

  task automatic check_contiguous(input string name, input int l);
    bit ok = 1'b1;
    int bad = 0;
    for (int i = 1; i < starts.size(); i++) begin
      if (ok && (starts[i] - starts[i-1]) != 10 * l) begin
        ok  = 1'b0;
        bad = starts[i] - starts[i-1];
      end
    end
    chk(ok, name, bad, 10 * l);
  endtask

  // Serial monitor: every cycle of a frame must match the expected start/data/stop bit.
  initial begin : monitor
    exp_t       e;
    logic [9:0] fr;
    bit         ok, aborted;
    int         bad_k, guard;
    logic       bad_got, bad_exp;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || ser_tx !== 1'b0) continue;
      starts.push_back(cyc);
      in_frame = 1'b1;
      chk(exp_q.size() != 0, "frame_expected", exp_q.size(), 1);
      if (exp_q.size() == 0) begin
        guard = 0;
        while (ser_tx !== 1'b1 && guard < 5000) begin
          @(negedge clk);
          guard++;
        end
      end else begin
        e       = exp_q.pop_front();
        fr      = {1'b1, e.b, 1'b0};
        ok      = 1'b1;
        aborted = 1'b0;
        bad_k   = -1;
        bad_got = 1'b0;
        bad_exp = 1'b0;
        for (int k = 0; k < 10 * e.l; k++) begin
          if (k > 0) @(negedge clk);
          if (reset !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (ok && ser_tx !== fr[k / e.l]) begin
            ok      = 1'b0;
            bad_k   = k;
            bad_got = ser_tx;
            bad_exp = fr[k / e.l];
          end
        end
        if (!aborted) chk(ok, $sformatf("frame_%02h_sample_%0d", e.b, bad_k), bad_got, bad_exp);
      end
      in_frame = 1'b0;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0, n0, n, div, l;
    reset       = 1'b1;
    valid       = 1'b0;
    data        = 8'h00;
    cfg_divider = 32'd217;
    repeat (3) @(negedge clk);
    chk(ser_tx == 1'b1, "rst_ser_tx", ser_tx, 1);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(ready == 1'b1, "rst_ready", ready, 1);
    chk(fifo_level == 5'd0, "rst_level", fifo_level, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single 'A' at 217 clocks per bit: start two edges after push, busy tracks the frame.
    starts.delete();
    push_byte(8'h41, 217);
    c0 = last_push_cyc;
    wait_start(1);
    chk(starts[0] - c0 == 3, "latency", starts[0] - c0, 3);
    wait_until_cyc(starts[0] + 2170 - 3);
    chk(busy == 1'b1, "busy_in_frame", busy, 1);
    wait_until_cyc(starts[0] + 2170 + 1);
    chk(busy == 1'b0, "busy_after_frame", busy, 0);
    chk(ser_tx == 1'b1, "line_idle_after", ser_tx, 1);
    wait_drain();

    // Fill past full at divider 4, then hold 0xFF until space frees up.
    cfg_divider = 32'd4;
    starts.delete();
    n0 = exp_count;
    for (int i = 0; i < 17; i++) begin
      push_byte(8'(i), 4);
      if (i == 0) c0 = last_push_cyc;
    end
    chk(fifo_level == 5'd16, "full_level", fifo_level, 16);
    chk(ready == 1'b0, "full_ready", ready, 0);
    push_byte(8'hFF, 4);
    wait_drain();
    chk(starts.size() == exp_count - n0, "burst_frames", starts.size(), exp_count - n0);
    chk(starts[0] - c0 == 3, "burst_latency", starts[0] - c0, 3);
    check_contiguous("burst_contiguous", 4);

    // Reset during data bit 3 of 0x55 with three bytes queued.
    cfg_divider = 32'd8;
    starts.delete();
    push_byte(8'h55, 8);
    push_byte(8'h11, 8);
    push_byte(8'h22, 8);
    push_byte(8'h33, 8);
    wait_start(1);
    wait_until_cyc(starts[0] + 36);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk(ser_tx == 1'b1, "mid_rst_ser_tx", ser_tx, 1);
    chk(fifo_level == 5'd0, "mid_rst_level", fifo_level, 0);
    chk(ready == 1'b1, "mid_rst_ready", ready, 1);
    @(negedge clk);
    reset = 1'b0;
    n = starts.size();
    repeat (400) @(negedge clk);
    chk(starts.size() == n, "no_tx_after_reset", starts.size() - n, 0);
    chk(busy == 1'b0, "busy_after_reset", busy, 0);

    // Divider change mid-frame applies to the next frame only.
    cfg_divider = 32'd217;
    starts.delete();
    push_byte(8'h3C, 217);
    wait_start(1);
    repeat (100) @(negedge clk);
    cfg_divider = 32'd108;
    push_byte(8'hA5, 108);
    wait_drain();
    chk(starts.size() == 2, "div_frames", starts.size(), 2);
    chk(starts[1] - starts[0] == 2170, "div_first_len", starts[1] - starts[0], 2170);

    // CR followed by 'B'; frames must be contiguous whether or not LF is inserted.
    cfg_divider = 32'd4;
    starts.delete();
    n0 = exp_count;
    push_byte(8'h0D, 4);
    push_byte(8'h42, 4);
    wait_drain();
    chk(starts.size() == exp_count - n0, "crlf_frames", starts.size(), exp_count - n0);
    check_contiguous("crlf_contiguous", 4);

    // Random traffic, including dividers below 2.
    for (int r = 0; r < 6; r++) begin
      div = $urandom_range(0, 12);
      l   = (div < 2) ? 2 : div;
      cfg_divider = 32'(div);
      n = $urandom_range(4, 24);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        push_byte(8'($urandom), l);
      end
      wait_drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
